seg_scan_decoder: RTL

Receive-side monitor for the multiplexed 8-digit, active-low seven-segment display bus. It samples the anode-select and segment lines every clock and requires each digit pattern to be stable before committing it. Committed patterns are decoded back into 4-bit digit codes plus decimal-point flags, and unknown patterns are flagged as errors. It sits on the display pins of the clock/alarm design, as the self-check loopback for the display driver and digit encoder, and for board-level test.

---
 rtl/seg_scan_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a multiplexed 8-digit, active-low
// seven-segment display bus. Samples an/seg every clock, waits for a pattern to
// be stable for STABLE_CNT qualified samples, then decodes it back into a digit
// code plus decimal-point flag, or flags it as an unknown pattern.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   an         digit select, active-low (an[i]=0 selects digit i)
//   seg        segment lines, active-low, {a,b,c,d,e,f,g,dp}
//   digits     committed 4-bit code per digit, digit i at [4i+3:4i], 4'hF = blank
//   dp         decimal point lit on digit i's last good commit
//   valid      digit i has had at least one good commit since reset
//   upd        one-cycle pulse per good commit, upd_idx = committed digit
//   err        one-cycle pulse per unknown stable pattern, err_idx/err_pat held
//   frame_done one-cycle pulse when all 8 digits have been captured
module seg_scan_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  seg,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  valid,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        err,
    output logic [2:0]  err_idx,
    output logic [7:0]  err_pat,
    output logic        frame_done
);

    localparam logic [7:0] STABLE = 8'(STABLE_CNT);

    logic [7:0] s_an, s_seg;     // registered inputs
    logic [7:0] p_an, p_seg;     // previous registered sample
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] seen_q, seen_d;
    logic [7:0] sel;
    logic       qual, same, cap, known, fd_d;
    logic [2:0] idx;
    logic [3:0] code;
    logic [7:0] seen_set;

    // Exactly one anode low: non-zero and a power of two after inversion.
    assign sel  = ~s_an;
    assign qual = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    assign same = ({s_an, s_seg} == {p_an, p_seg});

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!s_an[i]) idx = 3'(i);
        end
    end

    // Decode the seven segment lines; dp (seg[0]) is handled separately.
    always_comb begin
        known = 1'b1;
        code  = 4'hF;
        case (s_seg[7:1])
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001101: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: code = 4'hF;
            default:    known = 1'b0;
        endcase
    end

    always_comb begin
        if (!qual) begin
            cnt_d = 8'd0;
        end else if (!same) begin
            cnt_d = 8'd1;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        // Capture only on the transition into STABLE; a saturated hold does not recapture.
        cap = qual && (cnt_d == STABLE) && ((cnt_q != STABLE) || !same);
    end

    always_comb begin
        seen_set = seen_q | (8'd1 << idx);
        seen_d   = seen_q;
        fd_d     = 1'b0;
        if (cap) begin
            if (seen_set == 8'hFF) begin
                fd_d   = 1'b1;
                seen_d = 8'd0;
            end else begin
                seen_d = seen_set;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an       <= 8'hFF;
            s_seg      <= 8'hFF;
            p_an       <= 8'hFF;
            p_seg      <= 8'hFF;
            cnt_q      <= 8'd0;
            seen_q     <= 8'd0;
            digits     <= 32'hFFFF_FFFF;
            dp         <= 8'd0;
            valid      <= 8'd0;
            upd        <= 1'b0;
            upd_idx    <= 3'd0;
            err        <= 1'b0;
            err_idx    <= 3'd0;
            err_pat    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            s_an       <= an;
            s_seg      <= seg;
            p_an       <= s_an;
            p_seg      <= s_seg;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            upd        <= 1'b0;
            err        <= 1'b0;
            frame_done <= fd_d;
            if (cap) begin
                if (known) begin
                    digits[{idx, 2'b00} +: 4] <= code;
                    dp[idx]                   <= ~s_seg[0];
                    valid[idx]                <= 1'b1;
                    upd                       <= 1'b1;
                    upd_idx                   <= idx;
                end else begin
                    err     <= 1'b1;
                    err_idx <= idx;
                    err_pat <= s_seg;
                end
            end
        end
    end

endmodule
